seq_mod_reduce_25519: RTL and testbench
=======================================

Name: seq_mod_reduce_25519

Overview:
Sequential modular reducer for field arithmetic modulo p = 2^255 - 19. It sits directly downstream of the 256x256 sequential multiplier. It consumes the multiplier's 512-bit product on a start/done handshake and returns the canonical residue in [0, p-1], 255 bits zero-extended to 256. It uses the identity 2^255 ≡ 19 (mod p): two fold steps, then one conditional subtraction.

Parameters:
- B, 256, operand/result width. Only 256 is supported; the folding constants depend on it.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- x  input  512  value to reduce (multiplier product); sampled only on the edge that accepts start
- start  input  1  request. Accepted only in IDLE; ignored in any other state.
- result  output  256  x mod p; bit 255 is always 0; held until the next accepted start
- done  output  1  single-cycle pulse: result is valid
- busy  output  1  high from the accept edge until the edge that raises done

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, result=0, done=0, busy=0, internal accumulator=0.
  - Any operation in flight is abandoned; no done pulse follows.
- States: IDLE -> FOLD1 -> FOLD2 -> FINAL -> IDLE. One edge per state; no stalls.
- IDLE:
  - start=1 at edge t: capture x into the 512-bit accumulator; busy<=1; go to FOLD1.
  - start=0: hold; done<=0.
- FOLD1 (edge t+1):
  - H = acc[511:255] (257 b), L = acc[254:0].
  - acc <= L + 19*H, computed as (H<<4)+(H<<1)+H. Result fits in 263 bits; upper bits are zeroed.
- FOLD2 (edge t+2):
  - H2 = acc[262:255] (8 b), L2 = acc[254:0].
  - acc <= L2 + 19*H2. Bound: < 2^255 + 4845.
- FINAL (edge t+3):
  - If acc >= p: result <= acc - p; else result <= acc[255:0].
  - done<=1, busy<=0; go to IDLE.
  - One subtraction always suffices, because acc - p < 4864 < p.
- Latency:
  - done is high for exactly the one cycle following edge t+3.
  - result changes only on that edge.
- done deasserts on the next edge regardless of start.
- start=1 in the same cycle that done is high: accepted (state is IDLE). This allows back-to-back operation every 4 cycles.
- start held high continuously: a new operation is accepted every 4 edges. result is updated only at each FINAL.
- x changing while busy has no effect.
- Any 512-bit x is reduced correctly, not just products of reduced operands.
- Arithmetic is fully unsigned. No intermediate may be truncated below 263 bits before FOLD2.

Test Plan:
- x=0, start one cycle -> done pulses exactly 4 edges after the accept edge (cycle after t+3); result=0; busy high for 3 cycles.
- x=p=2^255-19 -> result=0. x=p-1 -> result=p-1. x=2^255 -> result=19 (exercises the FINAL no-subtract path after FOLD1).
- x=2^512-1 -> result=1443. x=(p-1)^2 -> result=1. x=2^255+18 -> result=37.
- Back-to-back: start=1 with x=2^255, then start=1 again in the done cycle with x=p+5 -> two done pulses 4 cycles apart, results 19 then 5.
- Start asserted during FOLD1 and FOLD2 with different x -> ignored; only the first result (and a single done) appears. x toggled while busy -> no effect.
- rst pulsed asynchronously mid-FOLD2 -> result=0, busy=0, done=0 immediately, with no later done pulse. A fresh start then completes normally.

Source files
------------

// File: rtl/seq_mod_reduce_25519.sv
// Sequential reducer modulo p = 2^255 - 19: two folds using 2^255 == 19 (mod p),
// then one conditional subtraction of p. Result is canonical in [0, p-1].
module seq_mod_reduce_25519 #(
  parameter int B = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*B-1:0] x,
  input  logic           start,
  output logic [B-1:0]   result,
  output logic           done,
  output logic           busy,
  output logic [1:0]     dbg_state
);

  // Handshake: start is accepted only on an edge where the block is IDLE (busy=0);
  // x is sampled on that edge only. done is a one-cycle pulse, result holds until
  // the next completion. start may be raised in the done cycle for back-to-back use.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FOLD1 = 2'd1,
    S_FOLD2 = 2'd2,
    S_FINAL = 2'd3
  } state_t;

  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

  state_t       r_state;
  logic [511:0] r_acc;

  logic [256:0] w_h1;
  logic [254:0] w_l;
  logic [262:0] w_fold1;
  logic [7:0]   w_h2;
  logic [255:0] w_fold2;
  logic         w_ge;
  logic [255:0] w_sub;

  assign w_h1 = r_acc[511:255];
  assign w_l  = r_acc[254:0];

  // 19*H as (H<<4)+(H<<1)+H, kept at full 263-bit width.
  assign w_fold1 = {8'd0, w_l}
                 + {2'd0, w_h1, 4'd0}
                 + {5'd0, w_h1, 1'b0}
                 + {6'd0, w_h1};

  assign w_h2    = r_acc[262:255];
  assign w_fold2 = {1'b0, w_l}
                 + {244'd0, w_h2, 4'd0}
                 + {247'd0, w_h2, 1'b0}
                 + {248'd0, w_h2};

  assign w_ge  = (r_acc[255:0] >= P);
  assign w_sub = r_acc[255:0] - P;

  assign dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_acc   <= x;
            busy    <= 1'b1;
            r_state <= S_FOLD1;
          end
        end
        S_FOLD1: begin
          r_acc   <= {249'd0, w_fold1};
          r_state <= S_FOLD2;
        end
        S_FOLD2: begin
          r_acc   <= {256'd0, w_fold2};
          r_state <= S_FINAL;
        end
        S_FINAL: begin
          result  <= w_ge ? w_sub : r_acc[255:0];
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mod_reduce_25519.sv
// Bench for seq_mod_reduce_25519: reference model is plain x % p with a fixed
// four-edge completion; directed vectors carry hand-computed residues.
module tb_seq_mod_reduce_25519;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] x = '0;
  logic         start = 1'b0;
  logic [255:0] result;
  logic         done;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] P;
  logic [511:0] P512;

  seq_mod_reduce_25519 #(.B(256)) dut (
    .clk(clk), .rst(rst), .x(x), .start(start),
    .result(result), .done(done), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model / scoreboard ----------------
  logic [255:0] exp_q[$];
  int           m_left = 0;   // edges until completion; 0 means idle
  logic         m_done = 1'b0;
  logic         m_busy = 1'b0;
  logic [255:0] m_result = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_left   = 0;
      m_done   = 1'b0;
      m_busy   = 1'b0;
      m_result = '0;
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (start) begin
          exp_q.push_back(256'(x % P512));
          m_left = 3;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_done   = 1'b1;
          m_result = exp_q.pop_front();
        end
      end
      m_busy = (m_left != 0);
    end
  end

  task automatic check256(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check256("cyc_done", {255'd0, done}, {255'd0, m_done});
      check256("cyc_busy", {255'd0, busy}, {255'd0, m_busy});
      check256("cyc_result", result, m_result);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Call at a negedge. Drives one request, optionally pokes start during FOLD1/FOLD2,
  // scrambles x while busy, returns at the negedge where done is seen.
  task automatic do_op(input string name, input logic [511:0] xv,
                       input logic [255:0] lit, input bit poke_start);
    int lat;
    int busy_n;
    x = xv;
    start = 1'b1;
    lat = 0;
    busy_n = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1 || lat == 2) begin
        start = poke_start;
        x = rand512();
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (busy) busy_n++;
    end
    check256({name, "_latency"}, 256'(lat), 256'd4);
    check256({name, "_busy_cycles"}, 256'(busy_n), 256'd3);
    check256({name, "_result"}, result, lit);
  endtask

  task automatic expect_no_done(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check256({name, "_extra_done"}, 256'(seen), 256'd0);
  endtask

  // ---------------- directed sequence ----------------
  logic [511:0] pm1sq;
  logic [511:0] pm1_512;
  logic [511:0] two255;

  initial begin
    P = (256'd1 << 255) - 256'd19;
    P512 = {256'd0, P};
    two255 = 512'd1 << 255;
    pm1_512 = P512 - 512'd1;
    pm1sq = pm1_512 * pm1_512;

    #1;
    check256("reset_result", result, 256'd0);
    check256("reset_done", {255'd0, done}, 256'd0);
    check256("reset_busy", {255'd0, busy}, 256'd0);
    check256("reset_state", {254'd0, dbg_state}, 256'd0);
    #11 rst = 1'b0;
    @(negedge clk);

    // Model self-pins: the reference arithmetic must agree with hand values.
    check256("model_pin_max", 256'((~512'd0) % P512), 256'd1443);
    check256("model_pin_sq", 256'(pm1sq % P512), 256'd1);

    do_op("zero", 512'd0, 256'd0, 1'b0);
    @(negedge clk);
    do_op("p", P512, 256'd0, 1'b0);
    @(negedge clk);
    do_op("p_minus_1", pm1_512, P - 256'd1, 1'b0);
    @(negedge clk);
    do_op("two255", two255, 256'd19, 1'b0);
    @(negedge clk);
    do_op("all_ones", ~512'd0, 256'd1443, 1'b0);
    @(negedge clk);
    do_op("pm1_sq", pm1sq, 256'd1, 1'b0);
    @(negedge clk);
    do_op("two255_p18", two255 + 512'd18, 256'd37, 1'b0);
    @(negedge clk);

    // Back-to-back: second start raised in the done cycle of the first.
    do_op("b2b_first", two255, 256'd19, 1'b0);
    do_op("b2b_second", P512 + 512'd5, 256'd5, 1'b0);
    @(negedge clk);

    // start poked during FOLD1/FOLD2 must be ignored.
    do_op("ignored_start", 512'd1 << 256, 256'd38, 1'b1);
    expect_no_done("ignored_start", 6);

    // start held high continuously with random x; the model checks every cycle.
    start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      x = rand512();
      @(negedge clk);
    end
    start = 1'b0;
    repeat (6) @(negedge clk);

    // Asynchronous reset in the middle of FOLD2.
    x = rand512();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check256("midrst_result", result, 256'd0);
    check256("midrst_done", {255'd0, done}, 256'd0);
    check256("midrst_busy", {255'd0, busy}, 256'd0);
    check256("midrst_state", {254'd0, dbg_state}, 256'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    expect_no_done("midrst", 8);

    do_op("after_rst", 512'd1 << 256, 256'd38, 1'b0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
